range_seq_gen: RTL and testbench
================================

RANGE_SEQ_GEN -- requirements
Module: range_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter TAPS, default 8'hB8, Galois LFSR feedback mask, WIDTH bits.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a sequence; sampled only in IDLE.
REQ-006 SHALL have port mode  input  2  pattern: 0 up-ramp, 1 down-ramp, 2 LFSR, 3 reserved.
REQ-007 SHALL have port seed  input  WIDTH  first word of the sequence.
REQ-008 SHALL have port len  input  8  number of data words, 1..255.
REQ-009 SHALL have port abort  input  1  cancel the running sequence.
REQ-010 SHALL have port data_out  output  WIDTH  word stream to the range-finder data input.
REQ-011 SHALL have port go  output  1  start strobe to the range finder.
REQ-012 SHALL have port finish  output  1  end strobe to the range finder.
REQ-013 SHALL have port busy  output  1  sequence in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port exp_range  output  WIDTH  expected max-minus-min of the emitted words.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse, start rejected.

Function
REQ-017 SHALL implement states IDLE, STREAM, FINISH, DONE; all outputs SHALL be registered.
REQ-018 IDLE, start=1 at edge T, valid config: SHALL capture mode/seed/len, enter STREAM; at T+1 data_out=word0, go=1, busy=1.
REQ-019 STREAM: word k SHALL appear in cycle T+1+k; go SHALL be 1 only with word0; finish=0.
REQ-020 After word len-1, SHALL enter FINISH for exactly one cycle (T+1+len): finish=1, go=0, data_out holds last word, busy=1.
REQ-021 DONE SHALL last one cycle (T+2+len): done=1, busy=0, exp_range updated; then IDLE.
REQ-022 Words: mode0 word[k+1]=word[k]+1 mod 2^WIDTH; mode1 word[k+1]=word[k]-1 mod 2^WIDTH; mode2 word[k+1]=(word[k]>>1) XOR (word[k][0] ? TAPS : 0).
REQ-023 SHALL track running min and max, unsigned, over all emitted words; exp_range=max-min, WIDTH bits, no wrap (max>=min).
REQ-024 exp_range SHALL hold its value from DONE until the next DONE; abort and cfg_err SHALL not change it.
REQ-025 len=0, mode=3, or mode=2 with seed=0 SHALL be rejected: cfg_err=1 for one cycle at T+1, state stays IDLE, no go.
REQ-026 len=1: SHALL emit go with word0 at T+1, finish at T+2, done at T+3, exp_range=0.
REQ-027 start SHALL be ignored in STREAM, FINISH and DONE; inputs other than start/abort SHALL be ignored outside IDLE sampling edge.
REQ-028 abort=1 in STREAM or FINISH SHALL force IDLE next cycle: go, finish, busy =0, done not pulsed; abort in IDLE/DONE SHALL have no effect.
REQ-029 abort and start together in IDLE SHALL give start priority (abort ignored in IDLE).
REQ-030 Between sequences data_out SHALL hold the last emitted word.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, data_out=0, go=0, finish=0, busy=0, done=0, cfg_err=0, exp_range=0, min/max trackers cleared.
REQ-032 Reset mid-sequence SHALL emit no further go/finish/done; first start after rst_n rises SHALL behave per REQ-018.

Verification
REQ-033 mode0 seed=FE len=4 -> data_out FE,FF,00,01; go with FE; finish next cycle; done; exp_range=FF.
REQ-034 mode1 seed=10 len=3 -> 10,0F,0E; exp_range=02; busy high for 4 cycles.
REQ-035 mode2 seed=01 len=3 TAPS=B8 -> 01,B8,5C; exp_range=B7.
REQ-036 mode2 seed=00, and separately len=0 -> cfg_err one cycle, no go, busy stays 0, exp_range unchanged.
REQ-037 mode0 seed=42 len=1 -> go+42 at T+1, finish T+2, done T+3, exp_range=00; start asserted during STREAM ignored.
REQ-038 abort in cycle 3 of a len=10 run, then rst_n pulse mid-run -> no finish/done, outputs per REQ-028/031, next run correct.

Source files
------------

// File: rtl/range_seq_gen.sv
// Purpose : test-pattern generator for a range-finder block; emits a ramp or LFSR word
//           stream framed by go/finish strobes and reports the expected max-minus-min.
// Latency : word0 appears one cycle after an accepted start, word k at +1+k, finish at +1+len, done at +2+len.
// Backpressure: none; the stream free-runs once started and only abort or reset cut it short.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request a sequence, sampled only in IDLE
//   mode[1:0]         0 up-ramp, 1 down-ramp, 2 Galois LFSR, 3 reserved (rejected)
//   seed[WIDTH-1:0]   first word of the sequence
//   len[7:0]          number of data words, 1..255
//   abort             cancel a running sequence (STREAM/FINISH only)
//   data_out          word stream, holds the last emitted word between sequences
//   go / finish       start / end strobes to the range finder
//   busy              sequence in progress (STREAM and FINISH)
//   done              one-cycle completion pulse
//   exp_range         max-minus-min of the emitted words, updated at done
//   cfg_err           one-cycle pulse when a start is rejected
module range_seq_gen #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'('hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       len,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] exp_range,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state,   w_state;
  logic [1:0]       r_mode,    w_mode;
  logic [7:0]       r_cnt,     w_cnt;      // words still to emit after the current one
  logic [WIDTH-1:0] r_data,    w_data;
  logic [WIDTH-1:0] r_min,     w_min;
  logic [WIDTH-1:0] r_max,     w_max;
  logic [WIDTH-1:0] r_range,   w_range;
  logic             r_go,      w_go;
  logic             r_finish,  w_finish;
  logic             r_busy,    w_busy;
  logic             r_done,    w_done;
  logic             r_cfg_err, w_cfg_err;

  logic [WIDTH-1:0] w_step;
  logic             w_cfg_ok;

  function automatic logic [WIDTH-1:0] f_next(input logic [1:0] m, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] n;
    n = d;
    case (m)
      2'd0:    n = d + WIDTH'(1);
      2'd1:    n = d - WIDTH'(1);
      2'd2:    n = (d >> 1) ^ (d[0] ? TAPS : '0);
      default: n = d;
    endcase
    return n;
  endfunction

  assign w_step = f_next(r_mode, r_data);

  // An all-zero LFSR seed would lock up at zero, so it is rejected along with
  // an empty length and the reserved mode.
  assign w_cfg_ok = (len != 8'd0) && (mode != 2'd3) && !((mode == 2'd2) && (seed == '0));

  always_comb begin
    w_state   = r_state;
    w_mode    = r_mode;
    w_cnt     = r_cnt;
    w_data    = r_data;
    w_min     = r_min;
    w_max     = r_max;
    w_range   = r_range;
    w_go      = 1'b0;
    w_finish  = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_cfg_err = 1'b0;

    case (r_state)
      S_IDLE: begin
        // abort is deliberately not looked at here, so start always wins.
        if (start) begin
          if (w_cfg_ok) begin
            w_state = S_STREAM;
            w_mode  = mode;
            w_cnt   = len - 8'd1;
            w_data  = seed;
            w_min   = seed;
            w_max   = seed;
            w_go    = 1'b1;
            w_busy  = 1'b1;
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end

      S_STREAM: begin
        if (abort) begin
          w_state = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          // Last word already on data_out; keep it there through FINISH.
          w_state  = S_FINISH;
          w_finish = 1'b1;
          w_busy   = 1'b1;
        end else begin
          w_data = w_step;
          w_min  = (w_step < r_min) ? w_step : r_min;
          w_max  = (w_step > r_max) ? w_step : r_max;
          w_cnt  = r_cnt - 8'd1;
          w_busy = 1'b1;
        end
      end

      S_FINISH: begin
        if (abort) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_range = r_max - r_min;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'd0;
      r_cnt     <= 8'd0;
      r_data    <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_range   <= '0;
      r_go      <= 1'b0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mode    <= w_mode;
      r_cnt     <= w_cnt;
      r_data    <= w_data;
      r_min     <= w_min;
      r_max     <= w_max;
      r_range   <= w_range;
      r_go      <= w_go;
      r_finish  <= w_finish;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_cfg_err <= w_cfg_err;
    end
  end

  assign data_out  = r_data;
  assign go        = r_go;
  assign finish    = r_finish;
  assign busy      = r_busy;
  assign done      = r_done;
  assign exp_range = r_range;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_range_seq_gen.sv
module tb_range_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [7:0] len;
  logic       abort;
  logic [7:0] data_out;
  logic       go;
  logic       finish;
  logic       busy;
  logic       done;
  logic [7:0] exp_range;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] len;
    logic       exp_err;
    logic [7:0] exp_range;
  } vec_t;

  typedef struct {
    logic [7:0] w;
    logic       first;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[10];
  vec_t hv;

  range_seq_gen #(.WIDTH(8), .TAPS(8'hB8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .len       (len),
    .abort     (abort),
    .data_out  (data_out),
    .go        (go),
    .finish    (finish),
    .busy      (busy),
    .done      (done),
    .exp_range (exp_range),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] d);
    logic [7:0] n;
    case (m)
      2'd0:    n = d + 8'd1;
      2'd1:    n = d - 8'd1;
      2'd2:    n = {1'b0, d[7:1]} ^ (d[0] ? 8'hB8 : 8'h00);
      default: n = d;
    endcase
    return n;
  endfunction

  // Stream monitor: every cycle the DUT is streaming, the next expected word is popped.
  always @(negedge clk) begin
    if (rst_n && busy && !finish) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra actual=%0h expected=none at %0t", data_out, $time);
      end else begin
        mon_e = q.pop_front();
        chk("data_out", {24'd0, data_out}, {24'd0, mon_e.w});
        chk("go_word0", {31'd0, go}, {31'd0, mon_e.first});
      end
    end
  end

  task automatic run_vec(input vec_t v, input logic with_abort);
    logic [7:0] w;
    logic [7:0] last;
    last = 8'h00;
    @(negedge clk);
    start = 1'b1; mode = v.mode; seed = v.seed; len = v.len; abort = with_abort;
    if (!v.exp_err) begin
      w = v.seed;
      for (int k = 0; k < int'(v.len); k++) begin
        q.push_back('{w, (k == 0)});
        last = w;
        w = model_next(v.mode, w);
      end
    end
    @(negedge clk);
    // Keep start high into STREAM and scramble config: both must be ignored.
    start = !v.exp_err; abort = 1'b0;
    mode = v.mode + 2'd1; seed = ~v.seed; len = v.len + 8'd3;
    chk("cfg_err_t1", {31'd0, cfg_err}, {31'd0, v.exp_err});
    chk("busy_t1", {31'd0, busy}, {31'd0, !v.exp_err});
    chk("go_t1", {31'd0, go}, {31'd0, !v.exp_err});
    if (v.exp_err) begin
      start = 1'b0;
      @(negedge clk);
      chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
      chk("busy_err", {31'd0, busy}, 32'd0);
      chk("range_err", {24'd0, exp_range}, {24'd0, v.exp_range});
    end else begin
      for (int k = 1; k < int'(v.len); k++) begin
        @(negedge clk);
        start = 1'b0;
        chk("finish_early", {31'd0, finish}, 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      chk("finish", {31'd0, finish}, 32'd1);
      chk("go_fin", {31'd0, go}, 32'd0);
      chk("busy_fin", {31'd0, busy}, 32'd1);
      chk("data_fin", {24'd0, data_out}, {24'd0, last});
      @(negedge clk);
      chk("done", {31'd0, done}, 32'd1);
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("finish_done", {31'd0, finish}, 32'd0);
      chk("exp_range", {24'd0, exp_range}, {24'd0, v.exp_range});
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("range_hold", {24'd0, exp_range}, {24'd0, v.exp_range});
      chk("data_hold", {24'd0, data_out}, {24'd0, last});
      chk("queue_empty", q.size(), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 8'hFE, 8'd4,   1'b0, 8'hFF};
    vecs[1] = '{2'd1, 8'h10, 8'd3,   1'b0, 8'h02};
    vecs[2] = '{2'd2, 8'h01, 8'd3,   1'b0, 8'hB7};
    vecs[3] = '{2'd2, 8'h00, 8'd5,   1'b1, 8'hB7};
    vecs[4] = '{2'd0, 8'h33, 8'd0,   1'b1, 8'hB7};
    vecs[5] = '{2'd3, 8'h11, 8'd2,   1'b1, 8'hB7};
    vecs[6] = '{2'd1, 8'h01, 8'd3,   1'b0, 8'hFF};
    vecs[7] = '{2'd2, 8'h80, 8'd4,   1'b0, 8'h70};
    vecs[8] = '{2'd0, 8'h00, 8'd255, 1'b0, 8'hFE};
    vecs[9] = '{2'd0, 8'h42, 8'd1,   1'b0, 8'h00};

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed = 8'h00; len = 8'd0; abort = 1'b0;
    #1;
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_go", {31'd0, go}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_range", {24'd0, exp_range}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // Abort during the third stream cycle of a 10-word run.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; seed = 8'h20; len = 8'd10;
    for (int k = 0; k < 3; k++) q.push_back('{8'h20 + 8'(k), (k == 0)});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_go", {31'd0, go}, 32'd0);
    chk("abort_finish", {31'd0, finish}, 32'd0);
    chk("abort_data_hold", {24'd0, data_out}, 32'h22);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done | finish}, 32'd0);
    end
    chk("abort_queue", q.size(), 32'd0);
    chk("abort_range", {24'd0, exp_range}, 32'h00);

    // start and abort together in IDLE: start wins.
    hv = '{2'd1, 8'h05, 8'd2, 1'b0, 8'h01};
    run_vec(hv, 1'b1);

    // Abort while in FINISH: no done, range unchanged.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; seed = 8'h10; len = 8'd2;
    q.push_back('{8'h10, 1'b1});
    q.push_back('{8'h11, 1'b0});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fin_abort_finish", {31'd0, finish}, 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("fin_abort_done", {31'd0, done}, 32'd0);
    chk("fin_abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("fin_abort_done2", {31'd0, done}, 32'd0);
    chk("fin_abort_range", {24'd0, exp_range}, 32'h01);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_range", {24'd0, exp_range}, 32'h01);

    // Reset pulse mid-run.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; seed = 8'h50; len = 8'd10;
    for (int k = 0; k < 10; k++) q.push_back('{8'h50 + 8'(k), (k == 0)});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_go_fin_done", {29'd0, go, finish, done}, 32'd0);
    chk("mid_rst_range", {24'd0, exp_range}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {28'd0, go, finish, done, busy}, 32'd0);
    end

    run_vec(vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
